mem_port_arbiter: RTL and testbench

- Shares the core's single-ported memory between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write).
- Sits between the fetch/control logic and the memory interface. It drives addr_o / wr_en_o / rd_en_o / mem_data_o and consumes mem_data_i.
- Priority: LS over IF, with a starvation guard so fetch is never blocked indefinitely.
- Fixed-latency memory; one transaction in flight at a time.

---
 rtl/mem_port_arbiter_pkg.sv | 37 +++
 rtl/mem_port_arbiter_prio.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch / load-store memory
// port arbiter.
package mem_port_arbiter_pkg;

  // Byte address width shared with the rest of the core.
  localparam int byte_addr_p = 16;

  // Width of the LS-streak counter; starve_lim_p must fit in it.
  localparam int streak_w_p = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } t_arb_state;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } t_arb_owner;

  // Saturating increment used by the starvation guard.
  function automatic logic [streak_w_p-1:0] sat_inc(
    input logic [streak_w_p-1:0] val,
    input logic [streak_w_p-1:0] lim
  );
    logic [streak_w_p-1:0] res;
    if (val >= lim) begin
      res = lim;
    end else begin
      res = val + {{(streak_w_p-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Winner selection between fetch and load/store, with a saturating counter of
// consecutive LS grants made while fetch was waiting. Once the counter reaches
// the limit, a waiting fetch is forced through ahead of LS.
module arb_prio_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int starve_lim_p = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       if_req_i,
  input  logic       ls_req_i,
  input  logic       accept_i,
  output t_arb_owner winner_o
);

  localparam logic [streak_w_p-1:0] lim_c = streak_w_p'(starve_lim_p);

  logic [streak_w_p-1:0] streak_q;
  logic [streak_w_p-1:0] streak_d;
  t_arb_owner            winner_s;

  // Pick the winner: LS unless fetch is waiting and has been starved long enough.
  always_comb begin
    winner_s = OWN_IF;
    if (ls_req_i && !(if_req_i && (streak_q == lim_c))) begin
      winner_s = OWN_LS;
    end else begin
      winner_s = OWN_IF;
    end
  end

  // Streak update on an accepted grant: clear on fetch, count LS while fetch waits.
  always_comb begin
    streak_d = streak_q;
    if (accept_i) begin
      if (winner_s == OWN_IF) begin
        streak_d = {streak_w_p{1'b0}};
      end else if (if_req_i) begin
        streak_d = sat_inc(streak_q, lim_c);
      end else begin
        streak_d = streak_q;
      end
    end else begin
      streak_d = streak_q;
    end
  end

  // Streak counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_q <= {streak_w_p{1'b0}};
    end else begin
      streak_q <= streak_d;
    end
  end

  assign winner_o = winner_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between instruction fetch
// (read-only) and load/store. One transaction is in flight at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int mem_lat_p    = 2,
  parameter int starve_lim_p = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   if_req_i,
  input  logic [byte_addr_p-1:0] if_addr_i,
  output logic                   if_gnt_o,
  output logic                   if_rvalid_o,
  output logic [31:0]            if_rdata_o,
  input  logic                   ls_req_i,
  input  logic                   ls_we_i,
  input  logic [byte_addr_p-1:0] ls_addr_i,
  input  logic [31:0]            ls_wdata_i,
  output logic                   ls_gnt_o,
  output logic                   ls_rvalid_o,
  output logic [31:0]            ls_rdata_o,
  output logic [byte_addr_p-1:0] addr_o,
  output logic                   wr_en_o,
  output logic                   rd_en_o,
  output logic [31:0]            mem_data_o,
  input  logic [31:0]            mem_data_i,
  output logic                   busy_o
);

  localparam logic [2:0] lat_c = 3'(mem_lat_p);

  t_arb_state             state_q, state_d;
  t_arb_owner             owner_q, owner_d;
  logic                   we_q, we_d;
  logic [byte_addr_p-1:0] addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [31:0]            if_rdata_q, if_rdata_d;
  logic [31:0]            ls_rdata_q, ls_rdata_d;
  logic                   accept_s;
  t_arb_owner             winner_s;

  assign accept_s = (state_q == ARB_IDLE) && (if_req_i || ls_req_i);

  arb_prio_select #(
    .starve_lim_p(starve_lim_p)
  ) u_prio (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .if_req_i(if_req_i),
    .ls_req_i(ls_req_i),
    .accept_i(accept_s),
    .winner_o(winner_s)
  );

  // Next-state logic: arbitrate in idle, issue for one cycle, wait out the latency, respond.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (accept_s) begin
          owner_d = winner_s;
          state_d = ARB_ISSUE;
          if (winner_s == OWN_LS) begin
            we_d    = ls_we_i;
            addr_d  = ls_addr_i;
            wdata_d = ls_wdata_i;
          end else begin
            // Fetch is always a read; write data is left as it was.
            we_d   = 1'b0;
            addr_d = if_addr_i;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        if (we_q) begin
          state_d = ARB_IDLE;
        end else begin
          cnt_d   = lat_c;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = ARB_RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_data_i;
          end else begin
            ls_rdata_d = mem_data_i;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, transaction and read-data registers; reset drops any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= {byte_addr_p{1'b0}};
      wdata_q    <= 32'h0000_0000;
      cnt_q      <= 3'd0;
      if_rdata_q <= 32'h0000_0000;
      ls_rdata_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // Strobes, grants and valids are pure decodes of the state and owner registers.
  assign rd_en_o     = (state_q == ARB_ISSUE) && !we_q;
  assign wr_en_o     = (state_q == ARB_ISSUE) && we_q;
  assign if_gnt_o    = (state_q == ARB_ISSUE) && (owner_q == OWN_IF);
  assign ls_gnt_o    = (state_q == ARB_ISSUE) && (owner_q == OWN_LS);
  assign if_rvalid_o = (state_q == ARB_RESP) && (owner_q == OWN_IF);
  assign ls_rvalid_o = (state_q == ARB_RESP) && (owner_q == OWN_LS);
  assign busy_o      = (state_q != ARB_IDLE);
  assign addr_o      = addr_q;
  assign mem_data_o  = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-2 instance (main tests) and a
// latency-1 instance (boundary), each with a behavioural memory model and a
// read-data scoreboard.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i;
  logic        if_req_i, ls_req_i, ls_we_i;
  logic [15:0] if_addr_i, ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o;
  logic [31:0] if_rdata_o, ls_rdata_o, mem_data_o, mem_data_i;
  logic [15:0] addr_o;
  logic        wr_en_o, rd_en_o, busy_o;

  logic        b_if_req_i;
  logic [15:0] b_if_addr_i;
  logic        b_if_gnt_o, b_if_rvalid_o, b_ls_gnt_o, b_ls_rvalid_o;
  logic [31:0] b_if_rdata_o, b_ls_rdata_o, b_mem_data_o, b_mem_data_i;
  logic [15:0] b_addr_o;
  logic        b_wr_en_o, b_rd_en_o, b_busy_o;

  mem_port_arbiter #(.mem_lat_p(2), .starve_lim_p(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o), .addr_o(addr_o), .wr_en_o(wr_en_o),
    .rd_en_o(rd_en_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .busy_o(busy_o)
  );

  mem_port_arbiter #(.mem_lat_p(1), .starve_lim_p(4)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(b_if_req_i), .if_addr_i(b_if_addr_i), .if_gnt_o(b_if_gnt_o),
    .if_rvalid_o(b_if_rvalid_o), .if_rdata_o(b_if_rdata_o),
    .ls_req_i(1'b0), .ls_we_i(1'b0), .ls_addr_i(16'h0000),
    .ls_wdata_i(32'h0000_0000), .ls_gnt_o(b_ls_gnt_o), .ls_rvalid_o(b_ls_rvalid_o),
    .ls_rdata_o(b_ls_rdata_o), .addr_o(b_addr_o), .wr_en_o(b_wr_en_o),
    .rd_en_o(b_rd_en_o), .mem_data_o(b_mem_data_o), .mem_data_i(b_mem_data_i),
    .busy_o(b_busy_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory contents as seen by the bench.
  function automatic logic [31:0] model(input logic [15:0] a);
    case (a)
      16'h0100: model = 32'hDEAD_BEEF;
      16'h0000: model = 32'h0000_000A;
      16'h0004: model = 32'h0000_000B;
      default:  model = {16'hC0DE, a};
    endcase
  endfunction

  // Fixed-latency memory: data valid mem_lat_p cycles after the read strobe, junk otherwise.
  logic [31:0] pipe0_q, pipe1_q, b_pipe0_q;
  always @(posedge clk_i) begin
    pipe0_q   <= rd_en_o ? model(addr_o) : 32'hBAD0_BAD0;
    pipe1_q   <= pipe0_q;
    b_pipe0_q <= b_rd_en_o ? model(b_addr_o) : 32'hBAD0_BAD0;
  end
  assign mem_data_i   = pipe1_q;
  assign b_mem_data_i = b_pipe0_q;

  // Scoreboard: expected read data pushed when a read request is driven.
  logic [31:0] if_exp_q[$];
  logic [31:0] ls_exp_q[$];
  logic [31:0] b_exp_q[$];

  always @(negedge clk_i) begin
    if (if_rvalid_o) begin
      if (if_exp_q.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
      else chk("if_rdata", if_rdata_o, if_exp_q.pop_front());
    end
    if (ls_rvalid_o) begin
      if (ls_exp_q.size() == 0) chk("ls_rvalid_unexpected", 32'd1, 32'd0);
      else chk("ls_rdata", ls_rdata_o, ls_exp_q.pop_front());
    end
    if (b_if_rvalid_o) begin
      if (b_exp_q.size() == 0) chk("b_if_rvalid_unexpected", 32'd1, 32'd0);
      else chk("b_if_rdata", b_if_rdata_o, b_exp_q.pop_front());
    end
  end

  // Requester rule: a pending request must hold req and address until its grant cycle.
  logic        if_pend_q = 1'b0, ls_pend_q = 1'b0;
  logic [15:0] if_addr_sv_q, ls_addr_sv_q;
  always @(posedge clk_i) begin
    if (rst_i) begin
      if_pend_q <= 1'b0;
      ls_pend_q <= 1'b0;
    end else begin
      if (if_pend_q && !if_gnt_o)
        assert (if_req_i && (if_addr_i == if_addr_sv_q)) else begin
          errors++;
          $error("FAIL if_req_rule: req=%0b addr=0x%04h required req=1 addr=0x%04h",
                 if_req_i, if_addr_i, if_addr_sv_q);
        end
      if (ls_pend_q && !ls_gnt_o)
        assert (ls_req_i && (ls_addr_i == ls_addr_sv_q)) else begin
          errors++;
          $error("FAIL ls_req_rule: req=%0b addr=0x%04h required req=1 addr=0x%04h",
                 ls_req_i, ls_addr_i, ls_addr_sv_q);
        end
      if_pend_q    <= if_req_i && !if_gnt_o;
      if_addr_sv_q <= if_addr_i;
      ls_pend_q    <= ls_req_i && !ls_gnt_o;
      ls_addr_sv_q <= ls_addr_i;
    end
  end

  // Per-cycle event masks (bit c = cycle c after the request was driven).
  logic [31:0] m_if_gnt, m_if_rv, m_ls_gnt, m_ls_rv, m_rd, m_wr, m_busy;
  logic [15:0] rd_addr;
  logic [31:0] wr_data;

  task automatic watch(input int n);
    m_if_gnt = 32'h0; m_if_rv = 32'h0; m_ls_gnt = 32'h0; m_ls_rv = 32'h0;
    m_rd = 32'h0; m_wr = 32'h0; m_busy = 32'h0;
    rd_addr = 16'h0; wr_data = 32'h0;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk_i);
      m_if_gnt[c] = if_gnt_o;
      m_if_rv[c]  = if_rvalid_o;
      m_ls_gnt[c] = ls_gnt_o;
      m_ls_rv[c]  = ls_rvalid_o;
      m_rd[c]     = rd_en_o;
      m_wr[c]     = wr_en_o;
      m_busy[c]   = busy_o;
      if (rd_en_o) rd_addr = addr_o;
      if (wr_en_o) wr_data = mem_data_o;
      if (if_gnt_o) if_req_i = 1'b0;
      if (ls_gnt_o) ls_req_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string seq;
    int    gnts;
    int    stores_left;
    logic  second_sent;
    logic [31:0] b_rv_mask, b_gnt_mask;

    rst_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = 16'h0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = 16'h0; ls_wdata_i = 32'h0;
    b_if_req_i = 1'b0; b_if_addr_i = 16'h0;

    // Reset state
    #2;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_strobes", {30'd0, rd_en_o, wr_en_o}, 32'd0);
    chk("rst_grants", {30'd0, if_gnt_o, ls_gnt_o}, 32'd0);
    chk("rst_addr", 32'(addr_o), 32'd0);
    chk("rst_rdata", if_rdata_o | ls_rdata_o | mem_data_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // 1. Single fetch
    if_req_i = 1'b1; if_addr_i = 16'h0100;
    if_exp_q.push_back(model(16'h0100));
    watch(7);
    chk("t1_rd_en", m_rd, 32'h0000_0002);
    chk("t1_addr", 32'(rd_addr), 32'h0000_0100);
    chk("t1_if_gnt", m_if_gnt, 32'h0000_0002);
    chk("t1_if_rvalid", m_if_rv, 32'h0000_0010);
    chk("t1_busy", m_busy, 32'h0000_001E);
    chk("t1_ls_quiet", m_ls_gnt | m_ls_rv | m_wr | ls_rdata_o, 32'h0);

    // 2. Store with a fetch pending behind it
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 16'h0200; ls_wdata_i = 32'h1234_5678;
    if_req_i = 1'b1; if_addr_i = 16'h0108;
    if_exp_q.push_back(model(16'h0108));
    watch(9);
    chk("t2_wr_en", m_wr, 32'h0000_0002);
    chk("t2_wdata", wr_data, 32'h1234_5678);
    chk("t2_ls_gnt", m_ls_gnt, 32'h0000_0002);
    chk("t2_ls_rvalid", m_ls_rv, 32'h0);
    chk("t2_busy", m_busy, 32'h0000_007A);
    chk("t2_if_gnt", m_if_gnt, 32'h0000_0008);
    chk("t2_if_rvalid", m_if_rv, 32'h0000_0040);
    ls_we_i = 1'b0;

    // 3. Simultaneous fetch and load: LS first
    ls_req_i = 1'b1; ls_addr_i = 16'h0300;
    ls_exp_q.push_back(model(16'h0300));
    if_req_i = 1'b1; if_addr_i = 16'h0104;
    if_exp_q.push_back(model(16'h0104));
    watch(11);
    chk("t3_ls_gnt", m_ls_gnt, 32'h0000_0002);
    chk("t3_ls_rvalid", m_ls_rv, 32'h0000_0010);
    chk("t3_if_gnt", m_if_gnt, 32'h0000_0040);
    chk("t3_if_rvalid", m_if_rv, 32'h0000_0200);
    chk("t3_rd_en", m_rd, 32'h0000_0042);

    // 4. Starvation guard: fetch held high against six back-to-back stores
    if_req_i = 1'b1; if_addr_i = 16'h0400;
    if_exp_q.push_back(model(16'h0400));
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 16'h0500; ls_wdata_i = 32'h1;
    seq = ""; gnts = 0; stores_left = 6;
    for (int c = 0; c < 200 && gnts < 8; c++) begin
      if (c > 0) @(negedge clk_i);
      if (ls_gnt_o) begin
        seq = {seq, "L"};
        gnts++;
        if (gnts == 4) chk("t4_streak_sat", 32'(dut.u_prio.streak_q), 32'd4);
        stores_left--;
        if (stores_left == 0) ls_req_i = 1'b0;
        else begin
          ls_addr_i  = ls_addr_i + 16'd4;
          ls_wdata_i = ls_wdata_i + 32'd1;
        end
      end
      if (if_gnt_o) begin
        seq = {seq, "I"};
        gnts++;
        chk("t4_streak_clr", 32'(dut.u_prio.streak_q), 32'd0);
        if (gnts == 8) if_req_i = 1'b0;
        else begin
          if_addr_i = 16'h0404;
          if_exp_q.push_back(model(16'h0404));
        end
      end
    end
    checks++;
    assert (seq == "LLLLILLI") else begin
      errors++;
      $error("FAIL t4_order: observed=%s expected=LLLLILLI", seq);
    end
    ls_we_i = 1'b0;
    repeat (8) @(negedge clk_i);

    // 5. Reset in the middle of a read wait
    if_req_i = 1'b1; if_addr_i = 16'h0108;
    if_exp_q.push_back(model(16'h0108));
    @(negedge clk_i);
    if_req_i = 1'b0;
    @(negedge clk_i);
    chk("t5_busy_before", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_strobes", {30'd0, rd_en_o, wr_en_o}, 32'd0);
    chk("t5_addr", 32'(addr_o), 32'd0);
    chk("t5_wdata", mem_data_o, 32'd0);
    chk("t5_if_rdata", if_rdata_o, 32'd0);
    chk("t5_ls_rdata", ls_rdata_o, 32'd0);
    if_exp_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    watch(8);
    chk("t5_no_rvalid", m_if_rv | m_ls_rv, 32'h0);
    chk("t5_idle", m_busy, 32'h0);

    // 6. Latency-1 instance, fetch re-asserted in its rvalid cycle
    b_if_req_i = 1'b1; b_if_addr_i = 16'h0000;
    b_exp_q.push_back(model(16'h0000));
    second_sent = 1'b0; b_rv_mask = 32'h0; b_gnt_mask = 32'h0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk_i);
      b_rv_mask[c]  = b_if_rvalid_o;
      b_gnt_mask[c] = b_if_gnt_o;
      if (b_if_gnt_o) b_if_req_i = 1'b0;
      if (b_if_rvalid_o && !second_sent) begin
        b_if_req_i = 1'b1; b_if_addr_i = 16'h0004;
        b_exp_q.push_back(model(16'h0004));
        second_sent = 1'b1;
      end
    end
    chk("t6_rvalid", b_rv_mask, 32'h0000_0088);
    chk("t6_gnt", b_gnt_mask, 32'h0000_0022);
    chk("t6_drained", 32'(b_exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
